// File: rtl/load_sequencer.sv
// Header/payload packet sequencer feeding dataload: buffers payload words in a
// small FIFO and replays them as load strobes. Optional macro: LOAD_SEQ_HDR_CHECK_EN.
module load_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] host_data_i,
  input  logic        host_valid_i,
  output logic        host_ready_o,
  input  logic        stall_i,
  output logic [31:0] data_o,
  output logic        load_en_o,
  output logic        load_type_o,
  output logic        load_done_o,
  output logic        err_o
);

  localparam int unsigned    PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_HDR,
    S_PAY
  } state_e;

  typedef struct packed {
    logic        last;
    logic        typ;
    logic [31:0] word;
  } entry_t;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic             type_q;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;

  logic [31:0]      data_q;
  logic             load_en_q;
  logic             load_type_q;
  logic             load_done_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             host_hs;
  logic             hdr_hs;
  logic             push;
  logic             pop;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_zero;
  logic             hdr_bad;
  entry_t           push_entry;
  entry_t           pop_entry;

  // Ready looks only at current occupancy, so a same-cycle pop never frees a slot early.
  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);
  assign host_ready_o = (state_q == S_HDR) || !fifo_full;

  assign host_hs  = host_valid_i && host_ready_o;
  assign hdr_hs   = host_hs && (state_q == S_HDR);
  assign push     = host_hs && (state_q == S_PAY);
  assign pop      = !fifo_empty && !stall_i;
  assign hdr_len  = host_data_i[LEN_W-1:0];
  assign hdr_zero = (hdr_len == '0);

`ifdef LOAD_SEQ_HDR_CHECK_EN
  assign hdr_bad = |host_data_i[30:LEN_W];
`else
  logic unused_rsvd;
  assign hdr_bad     = 1'b0;
  assign unused_rsvd = ^host_data_i[30:LEN_W];
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.last = (rem_q == LEN_W'(1));
    push_entry.typ  = type_q;
    push_entry.word = host_data_i;
  end

  assign pop_entry = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      rem_q   <= '0;
      type_q  <= 1'b0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (hdr_hs && !hdr_bad && !hdr_zero) begin
            state_q <= S_PAY;
            rem_q   <= hdr_len;
            type_q  <= host_data_i[31];
          end
        end
        S_PAY: begin
          if (push) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= S_HDR;
            end
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count alone decides
  // which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  // A zero-length header completes immediately with a bare done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      load_en_q   <= 1'b0;
      load_type_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_en_q   <= pop;
      load_done_q <= (pop && pop_entry.last) || (hdr_hs && hdr_zero && !hdr_bad);
      if (pop) begin
        data_q      <= pop_entry.word;
        load_type_q <= pop_entry.typ;
      end
    end
  end

`ifdef LOAD_SEQ_HDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= hdr_hs && hdr_bad;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign data_o      = data_q;
  assign load_en_o   = load_en_q;
  assign load_type_o = load_type_q;
  assign load_done_o = load_done_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer: directed packets plus random traffic
// against a queue-based transaction model of the packet stream.
module tb_load_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] host_data_i;
  logic        host_valid_i;
  logic        host_ready_o;
  logic        stall_i;
  logic [31:0] data_o;
  logic        load_en_o;
  logic        load_type_o;
  logic        load_done_o;
  logic        err_o;

  always #5 clk = ~clk;

  load_sequencer #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_data_i  (host_data_i),
    .host_valid_i (host_valid_i),
    .host_ready_o (host_ready_o),
    .stall_i      (stall_i),
    .data_o       (data_o),
    .load_en_o    (load_en_o),
    .load_type_o  (load_type_o),
    .load_done_o  (load_done_o),
    .err_o        (err_o)
  );

  typedef struct {
    bit          last;
    bit          typ;
    logic [31:0] word;
  } m_ent_t;

  typedef struct {
    int          cyc;
    bit          en;
    bit          done;
    bit          err;
    bit          typ;
    logic [31:0] data;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit hs_seen;

  // Reference model: packet parser state plus the queue of buffered payload words.
  m_ent_t      m_q[$];
  bit          m_hdr;
  int          m_rem;
  bit          m_type;
  bit          e_en, e_done, e_err, e_type;
  logic [31:0] e_data;

  obs_t obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hdr  = 1'b1;
    m_rem  = 0;
    m_type = 1'b0;
    e_en   = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    e_type = 1'b0;
    e_data = '0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit s);
    int     occ;
    bit     rdy;
    int     n;
    bit     bad;
    m_ent_t ent;
    occ    = m_q.size();
    rdy    = m_hdr || (occ < DEPTH);
    e_en   = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (occ > 0 && !s) begin
      ent    = m_q.pop_front();
      e_en   = 1'b1;
      e_data = ent.word;
      e_type = ent.typ;
      e_done = ent.last;
    end
    if (v && rdy) begin
      if (m_hdr) begin
        n   = int'(d % (32'd1 << LEN_W));
        bad = 1'b0;
`ifdef LOAD_SEQ_HDR_CHECK_EN
        bad = ((d >> LEN_W) % (32'd1 << (31 - LEN_W))) != 0;
`endif
        if (bad) begin
          e_err = 1'b1;
        end else if (n == 0) begin
          e_done = 1'b1;
        end else begin
          m_hdr  = 1'b0;
          m_rem  = n;
          m_type = d[31];
        end
      end else begin
        m_q.push_back('{last: (m_rem == 1), typ: m_type, word: d});
        m_rem--;
        if (m_rem == 0) m_hdr = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at posedge+2, then advance the model.
  task automatic cycle(input bit v, input logic [31:0] d, input bit s);
    cyc++;
    host_valid_i = v;
    host_data_i  = d;
    stall_i      = s;
    #1;
    check("load_en", load_en_o, e_en);
    check("load_done", load_done_o, e_done);
    check("data", data_o, e_data);
    check("load_type", load_type_o, e_type);
    check("err", err_o, e_err);
    check("host_ready", host_ready_o, m_hdr || (m_q.size() < DEPTH));
    hs_seen = v && host_ready_o;
    if (load_en_o || load_done_o || err_o)
      obs_q.push_back('{cyc: cyc, en: load_en_o, done: load_done_o, err: err_o,
                        typ: load_type_o, data: data_o});
    @(posedge clk);
    model_step(v, d, s);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit s);
    int tries;
    tries   = 0;
    hs_seen = 1'b0;
    while (!hs_seen && tries < 50) begin
      cycle(1'b1, d, s);
      tries++;
    end
    if (!hs_seen) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    host_valid_i = 1'b0;
    host_data_i  = '0;
    stall_i      = 1'b0;
    #1;
    check("rst_data", data_o, 32'd0);
    check("rst_load_en", load_en_o, 1'b0);
    check("rst_load_type", load_type_o, 1'b0);
    check("rst_load_done", load_done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_host_ready", host_ready_o, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cyc;
    int accepted;
    int tries;
    int dones;

    do_reset();
    obs_q.delete();
    idle(4);
    check("idle_no_strobe", obs_q.size(), 0);

    // Weight packet, back to back, no stall.
    obs_q.delete();
    send_word(32'h0000_0003, 1'b0);
    send_word(32'h0000_00A1, 1'b0);
    acc_cyc = cyc;
    send_word(32'h0000_00A2, 1'b0);
    send_word(32'h0000_00A3, 1'b0);
    idle(4);
    check("w_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("w_en", obs_q[i].en, 1'b1);
        check("w_data", obs_q[i].data, 32'hA1 + i);
        check("w_type", obs_q[i].typ, 1'b0);
        check("w_done", obs_q[i].done, (i == 2));
      end
      check("w_latency", obs_q[0].cyc - acc_cyc, 2);
      check("w_back_to_back", obs_q[2].cyc - obs_q[0].cyc, 2);
    end

    // Input packet of 8 words with the downstream stalled.
    obs_q.delete();
    send_word(32'h8000_0008, 1'b1);
    accepted = 0;
    tries    = 0;
    while (accepted < 8 && tries < 10) begin
      cycle(1'b1, 32'hC000_0000 + accepted, 1'b1);
      if (hs_seen) accepted++;
      tries++;
    end
    check("bp_accepted", accepted, DEPTH);
    check("bp_ready_low", host_ready_o, 1'b0);
    check("bp_no_strobe", obs_q.size(), 0);
    for (int i = accepted; i < 8; i++) send_word(32'hC000_0000 + i, 1'b0);
    idle(DEPTH + 4);
    check("bp_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("bp_data", obs_q[i].data, 32'hC000_0000 + i);
        check("bp_type", obs_q[i].typ, 1'b1);
        check("bp_done", obs_q[i].done, (i == 7));
      end
    end

    // Weight packet immediately followed by an input packet.
    obs_q.delete();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h0000_00B1, 1'b0);
    send_word(32'h0000_00B2, 1'b0);
    send_word(32'h8000_0002, 1'b0);
    send_word(32'h0000_00C1, 1'b0);
    send_word(32'h0000_00C2, 1'b0);
    idle(5);
    check("il_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      dones = 0;
      for (int i = 0; i < 4; i++) begin
        check("il_type", obs_q[i].typ, (i >= 2));
        if (obs_q[i].done) dones++;
      end
      check("il_data0", obs_q[0].data, 32'hB1);
      check("il_data3", obs_q[3].data, 32'hC2);
      check("il_dones", dones, 2);
    end

    // Zero-length header.
    obs_q.delete();
    send_word(32'h0000_0000, 1'b0);
    idle(3);
    check("zl_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("zl_en", obs_q[0].en, 1'b0);
      check("zl_done", obs_q[0].done, 1'b1);
    end

`ifdef LOAD_SEQ_HDR_CHECK_EN
    obs_q.delete();
    send_word(32'h0001_0002, 1'b0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_00E1, 1'b0);
    idle(3);
    check("er_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("er_err", obs_q[0].err, 1'b1);
      check("er_en0", obs_q[0].en, 1'b0);
      check("er_data", obs_q[1].data, 32'hE1);
      check("er_done", obs_q[1].done, 1'b1);
    end
`endif

    // Reset in the middle of a 5-word packet.
    obs_q.delete();
    send_word(32'h0000_0005, 1'b0);
    send_word(32'h0000_0D01, 1'b0);
    send_word(32'h0000_0D02, 1'b0);
    do_reset();
    obs_q.delete();
    idle(5);
    check("mr_no_strobe", obs_q.size(), 0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_0DD1, 1'b0);
    idle(3);
    check("mr_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("mr_data", obs_q[0].data, 32'h0000_0DD1);
      check("mr_done", obs_q[0].done, 1'b1);
    end

    // Random traffic with random stalls, headers and reserved bits.
    for (int i = 0; i < 600; i++) begin
      bit          v;
      bit          s;
      logic [31:0] d;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 3);
      d = $urandom;
      if (m_hdr) begin
        d[15:0] = 16'($urandom_range(0, 6));
        if ($urandom_range(0, 3) != 0) d[30:16] = '0;
      end
      cycle(v, d, s);
    end
    idle(DEPTH + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
